hicore_agu_queue: RTL and testbench
===================================

// Module: hicore_agu_queue
// PURPOSE
//  Parametrised next-generation address-generation unit between the issue stage and the LSU.
//  - Computes the effective address, write mask, replicated write data and misalignment flag.
//  - Buffers up to DEPTH memory ops in program order, so issue is not stalled by LSU backpressure.
//  - Releases stores only when they reach the ROB head; loads are released freely.
//  - Supports XLEN 32/64 (doubleword access when XLEN=64) and a full flush.
// PARAMETERS
//  XLEN       32  register/data width; 32 or 64
//  ADDR_W     32  address width, <= XLEN
//  DEPTH      4   queue entries; power of 2, >= 2
//  ROB_PTR_W  5   ROB pointer width
//  INFO_W     64  opaque side-band payload (pc/irq/excp), passed through untouched
// PORTS
//  clk           in   1          clock; all state on rising edge
//  rst           in   1          synchronous, active-high reset
//  i_valid       in   1          issue offers an op
//  i_ready       out  1          queue accepts (= count < DEPTH)
//  i_src1        in   XLEN       base
//  i_src2        in   XLEN       offset
//  i_src3        in   XLEN       store data
//  i_msg         in   3          [1:0] size 00=B 01=H 10=W 11=D; [2] unsigned (loads only)
//  i_load        in   1          load op
//  i_store       in   1          store op (exactly one of i_load/i_store is set with i_valid)
//  i_rob_ptr     in   ROB_PTR_W  ROB entry of the op
//  i_info        in   INFO_W     side-band payload
//  rob_head_ptr  in   ROB_PTR_W  current LSU-visible ROB head
//  flush         in   1          pipeline flush
//  o_valid       out  1          head entry offered to LSU
//  o_ready       in   1          LSU accepts
//  o_read        out  1          1=load 0=store
//  o_unsigned    out  1          unsigned load
//  o_size        out  2          access size code
//  o_addr        out  ADDR_W     effective address
//  o_wmask       out  XLEN/8     byte-lane write mask
//  o_wdata       out  XLEN       lane-replicated store data
//  o_misalign    out  1          address misaligned, or D size used with XLEN=32
//  o_rob_ptr     out  ROB_PTR_W  ROB entry
//  o_info        out  INFO_W     side-band payload
//  o_count       out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
//  - Reset: head=tail=count=0; o_valid=0; i_ready=1; all o_* payload outputs 0.
//  - Enqueue when i_valid & i_ready & ~flush.
//    - Entry is computed at enqueue:
//      - addr = (src1+src2)[ADDR_W-1:0], carry discarded.
//      - unsigned = load & msg[2].
//    - The queue is a circular buffer; tail wraps DEPTH-1 -> 0.
//  - Store write mask (L = log2(XLEN/8) low address bits, a = addr):
//    - B: 1 << a[L-1:0]
//    - H: 2'b11 << {a[L-1:1],1'b0}
//    - W: 4'hF << {a[L-1:2],2'b00}; for XLEN=32 this is all ones.
//    - D: all ones.
//  - Store write data is src3 low bytes replicated to fill XLEN.
//  - Loads store wmask=0 and wdata=0.
//  - misalign = H&a[0] | W&|a[1:0] | D&|a[2:0] | (D & XLEN==32).
//    - Misaligned ops are still queued and delivered to the LSU, flagged, with the same ordering rules.
//  - Head release: o_valid = ~empty & ~flush & (head.read | head.rob_ptr == rob_head_ptr).
//  - In-order release: a load behind a waiting store also waits.
//  - Dequeue when o_valid & o_ready; head wraps.
//  - o_* payload outputs mirror the head entry at all times.
//  - Latency: an op enqueued in cycle N is earliest visible on o_valid in cycle N+1. There is no bypass.
//  - Full: i_ready=0 even if the same cycle dequeues. The freed slot is visible the next cycle.
//  - Enqueue and dequeue in the same cycle: count is unchanged.
//  - Flush: o_valid=0 and i_ready is ignored in the flush cycle; no enqueue and no dequeue.
//    - Next cycle: head=tail=count=0, all entries discarded.
//  - rst has priority over flush and over any handshake.
// TESTING
//  - Load, DEPTH=4, src1=0x1000, src2=0x3, B size, o_ready=1:
//    -> next cycle o_valid=1, o_addr=0x1003, o_read=1, o_wmask=0, o_misalign=0.
//  - Store H at 0x2002, src3=0xABCD, XLEN=32, rob_ptr=7, head=5:
//    -> o_valid=0; head changes to 7 -> o_valid=1, o_wmask=4'b1100, o_wdata=0xABCDABCD.
//  - o_ready=0, push 5 ops:
//    -> i_ready=0 after 4; o_count=4; drain order matches issue order.
//    -> pointer wrap verified over 10 ops.
//  - XLEN=64: D store at 0x...8 -> o_wmask=8'hFF, misalign=0; D at 0x...4 -> o_misalign=1.
//    - XLEN=32: D at 0x0 -> o_misalign=1.
//  - 3 entries queued, flush=1 together with i_valid=1:
//    -> flush cycle o_valid=0, nothing enqueued; next cycle o_count=0, o_valid=0.
//  - Assert rst mid-stream with 2 entries queued -> next cycle o_count=0, i_ready=1, o_valid=0.

Source files
------------

// File: rtl/hicore_agu_queue.sv
// rtl/hicore_agu_queue.sv - address-generation unit with in-order memory-op queue toward the LSU
module hicore_agu_queue #(
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 4,
  parameter int ROB_PTR_W = 5,
  parameter int INFO_W    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [XLEN-1:0]          i_src1,
  input  logic [XLEN-1:0]          i_src2,
  input  logic [XLEN-1:0]          i_src3,
  input  logic [2:0]               i_msg,
  input  logic                     i_load,
  input  logic                     i_store,
  input  logic [ROB_PTR_W-1:0]     i_rob_ptr,
  input  logic [INFO_W-1:0]        i_info,
  input  logic [ROB_PTR_W-1:0]     rob_head_ptr,
  input  logic                     flush,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic                     o_read,
  output logic                     o_unsigned,
  output logic [1:0]               o_size,
  output logic [ADDR_W-1:0]        o_addr,
  output logic [XLEN/8-1:0]        o_wmask,
  output logic [XLEN-1:0]          o_wdata,
  output logic                     o_misalign,
  output logic [ROB_PTR_W-1:0]     o_rob_ptr,
  output logic [INFO_W-1:0]        o_info,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int BW = XLEN / 8;
  localparam int L  = $clog2(BW);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // queue storage, one slot per buffered op
  logic                 r_read     [DEPTH];
  logic                 r_unsigned [DEPTH];
  logic [1:0]           r_size     [DEPTH];
  logic [ADDR_W-1:0]    r_addr     [DEPTH];
  logic [BW-1:0]        r_wmask    [DEPTH];
  logic [XLEN-1:0]      r_wdata    [DEPTH];
  logic                 r_misalign [DEPTH];
  logic [ROB_PTR_W-1:0] r_rob      [DEPTH];
  logic [INFO_W-1:0]    r_info     [DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [XLEN-1:0]   w_sum;
  logic [ADDR_W-1:0] w_addr;
  logic              w_is_store;
  logic [L-1:0]      w_sh_b;
  logic [L-1:0]      w_sh_h;
  logic [L-1:0]      w_sh_w;
  logic [BW-1:0]     w_mask;
  logic [XLEN-1:0]   w_data;
  logic              w_mis;
  logic              w_empty;
  logic              w_enq;
  logic              w_deq;

  assign w_sum      = i_src1 + i_src2;
  assign w_addr     = w_sum[ADDR_W-1:0];
  assign w_is_store = i_store & ~i_load;

  // lane mask and lane-replicated data for the incoming op; loads carry neither
  always_comb begin
    w_sh_b = w_addr[L-1:0];
    w_sh_h = w_sh_b & ~L'(1);
    w_sh_w = w_sh_b & ~L'(3);
    w_mask = '0;
    w_data = '0;
    case (i_msg[1:0])
      2'b00: begin
        w_mask = BW'(1) << w_sh_b;
        w_data = {(XLEN/8){i_src3[7:0]}};
      end
      2'b01: begin
        w_mask = BW'(3) << w_sh_h;
        w_data = {(XLEN/16){i_src3[15:0]}};
      end
      2'b10: begin
        w_mask = BW'(15) << w_sh_w;
        w_data = {(XLEN/32){i_src3[31:0]}};
      end
      default: begin
        w_mask = '1;
        w_data = i_src3;
      end
    endcase
    if (!w_is_store) begin
      w_mask = '0;
      w_data = '0;
    end
  end

  // a doubleword access is never legal on a 32-bit datapath
  assign w_mis = ((i_msg[1:0] == 2'b01) & w_addr[0])
               | ((i_msg[1:0] == 2'b10) & (|w_addr[1:0]))
               | ((i_msg[1:0] == 2'b11) & ((|w_addr[2:0]) | (XLEN == 32)));

  assign w_empty = (r_count == '0);
  assign i_ready = (r_count < CW'(DEPTH));
  assign o_valid = ~w_empty & ~flush & (r_read[r_head] | (r_rob[r_head] == rob_head_ptr));
  assign w_enq   = i_valid & i_ready & ~flush;
  assign w_deq   = o_valid & o_ready;

  assign o_read     = r_read[r_head];
  assign o_unsigned = r_unsigned[r_head];
  assign o_size     = r_size[r_head];
  assign o_addr     = r_addr[r_head];
  assign o_wmask    = r_wmask[r_head];
  assign o_wdata    = r_wdata[r_head];
  assign o_misalign = r_misalign[r_head];
  assign o_rob_ptr  = r_rob[r_head];
  assign o_info     = r_info[r_head];
  assign o_count    = r_count;

  // pointer and occupancy bookkeeping; flush empties the queue for the next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PW'(1);
      if (w_deq) r_head <= r_head + PW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // slot write at the tail; reset clears every slot so the head payload reads zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_read[k]     <= 1'b0;
        r_unsigned[k] <= 1'b0;
        r_size[k]     <= '0;
        r_addr[k]     <= '0;
        r_wmask[k]    <= '0;
        r_wdata[k]    <= '0;
        r_misalign[k] <= 1'b0;
        r_rob[k]      <= '0;
        r_info[k]     <= '0;
      end
    end else if (w_enq) begin
      r_read[r_tail]     <= ~w_is_store;
      r_unsigned[r_tail] <= i_load & i_msg[2];
      r_size[r_tail]     <= i_msg[1:0];
      r_addr[r_tail]     <= w_addr;
      r_wmask[r_tail]    <= w_mask;
      r_wdata[r_tail]    <= w_data;
      r_misalign[r_tail] <= w_mis;
      r_rob[r_tail]      <= i_rob_ptr;
      r_info[r_tail]     <= i_info;
    end
  end

endmodule

// File: tb/tb_hicore_agu_queue.sv
// tb/tb_hicore_agu_queue.sv - directed self-checking bench for hicore_agu_queue (XLEN 32 and 64)
module tb_hicore_agu_queue;

  logic        clk;
  logic        rst;
  logic        v32, v64;
  logic [63:0] src1, src2, src3;
  logic [2:0]  msg;
  logic        load, store;
  logic [4:0]  rob, rob_head;
  logic [63:0] info;
  logic        flush;
  logic        o_ready;

  logic        irdy32, ov32, rd32, uns32, mis32;
  logic [1:0]  sz32;
  logic [31:0] addr32, wd32;
  logic [3:0]  wm32;
  logic [4:0]  robo32;
  logic [63:0] info32;
  logic [2:0]  cnt32;

  logic        irdy64, ov64, rd64, uns64, mis64;
  logic [1:0]  sz64;
  logic [63:0] addr64, wd64;
  logic [7:0]  wm64;
  logic [4:0]  robo64;
  logic [63:0] info64;
  logic [2:0]  cnt64;

  int total = 0;
  int bad   = 0;

  hicore_agu_queue u32 (
    .clk(clk), .rst(rst), .i_valid(v32), .i_ready(irdy32),
    .i_src1(src1[31:0]), .i_src2(src2[31:0]), .i_src3(src3[31:0]),
    .i_msg(msg), .i_load(load), .i_store(store), .i_rob_ptr(rob), .i_info(info),
    .rob_head_ptr(rob_head), .flush(flush),
    .o_valid(ov32), .o_ready(o_ready), .o_read(rd32), .o_unsigned(uns32), .o_size(sz32),
    .o_addr(addr32), .o_wmask(wm32), .o_wdata(wd32), .o_misalign(mis32),
    .o_rob_ptr(robo32), .o_info(info32), .o_count(cnt32)
  );

  hicore_agu_queue #(.XLEN(64), .ADDR_W(64)) u64 (
    .clk(clk), .rst(rst), .i_valid(v64), .i_ready(irdy64),
    .i_src1(src1), .i_src2(src2), .i_src3(src3),
    .i_msg(msg), .i_load(load), .i_store(store), .i_rob_ptr(rob), .i_info(info),
    .rob_head_ptr(rob_head), .flush(1'b0),
    .o_valid(ov64), .o_ready(o_ready), .o_read(rd64), .o_unsigned(uns64), .o_size(sz64),
    .o_addr(addr64), .o_wmask(wm64), .o_wdata(wd64), .o_misalign(mis64),
    .o_rob_ptr(robo64), .o_info(info64), .o_count(cnt64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; v32 = 1'b0; v64 = 1'b0; src1 = '0; src2 = '0; src3 = '0;
    msg = '0; load = 1'b0; store = 1'b0; rob = '0; rob_head = '0; info = '0;
    flush = 1'b0; o_ready = 1'b1;
    step();
    step();
    chk("rst_ovalid", 64'(ov32), 64'h0);
    chk("rst_iready", 64'(irdy32), 64'h1);
    chk("rst_count", 64'(cnt32), 64'h0);
    chk("rst_addr", 64'(addr32), 64'h0);
    chk("rst_info", info32, 64'h0);
    chk("rst64_count", 64'(cnt64), 64'h0);
    rst = 1'b0;

    // load byte, released immediately
    src1 = 64'h1000; src2 = 64'h3; msg = 3'b000; load = 1'b1; store = 1'b0;
    rob = 5'd0; info = 64'h55; v32 = 1'b1;
    chk("ld_pre_valid", 64'(ov32), 64'h0);
    step();
    v32 = 1'b0;
    chk("ld_valid", 64'(ov32), 64'h1);
    chk("ld_addr", 64'(addr32), 64'h1003);
    chk("ld_read", 64'(rd32), 64'h1);
    chk("ld_wmask", 64'(wm32), 64'h0);
    chk("ld_mis", 64'(mis32), 64'h0);
    chk("ld_info", info32, 64'h55);
    chk("ld_count", 64'(cnt32), 64'h1);
    step();
    chk("ld_drained", 64'(cnt32), 64'h0);
    chk("ld_drained_valid", 64'(ov32), 64'h0);

    // halfword store waits for its ROB head, load behind it waits too
    src1 = 64'h2000; src2 = 64'h2; src3 = 64'hABCD; msg = 3'b001; load = 1'b0; store = 1'b1;
    rob = 5'd7; rob_head = 5'd5; v32 = 1'b1;
    step();
    src1 = 64'h3000; src2 = 64'h0; msg = 3'b010; load = 1'b1; store = 1'b0; rob = 5'd8;
    step();
    v32 = 1'b0;
    chk("st_wait_valid", 64'(ov32), 64'h0);
    chk("st_wait_count", 64'(cnt32), 64'h2);
    chk("st_wmask", 64'(wm32), 64'hC);
    chk("st_wdata", 64'(wd32), 64'hABCDABCD);
    chk("st_read", 64'(rd32), 64'h0);
    rob_head = 5'd7;
    #1;
    chk("st_release", 64'(ov32), 64'h1);
    step();
    chk("st_next_valid", 64'(ov32), 64'h1);
    chk("st_next_read", 64'(rd32), 64'h1);
    chk("st_next_addr", 64'(addr32), 64'h3000);
    chk("st_next_count", 64'(cnt32), 64'h1);
    step();
    chk("st_drained", 64'(cnt32), 64'h0);

    // fill to full with LSU stalled, then drain in order
    o_ready = 1'b0; load = 1'b1; store = 1'b0; msg = 3'b010; src2 = 64'h0; v32 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src1 = 64'(i * 4);
      step();
    end
    chk("full_count", 64'(cnt32), 64'h4);
    chk("full_iready", 64'(irdy32), 64'h0);
    src1 = 64'h40;
    step();
    chk("full_hold_count", 64'(cnt32), 64'h4);
    chk("full_head_addr", 64'(addr32), 64'h0);
    o_ready = 1'b1;
    step();
    chk("full_deq_count", 64'(cnt32), 64'h3);
    chk("full_deq_addr", 64'(addr32), 64'h4);
    chk("full_deq_iready", 64'(irdy32), 64'h1);
    v32 = 1'b0;
    step();
    chk("drain_addr2", 64'(addr32), 64'h8);
    step();
    chk("drain_addr3", 64'(addr32), 64'hC);
    chk("drain_count3", 64'(cnt32), 64'h1);
    step();
    chk("drain_empty", 64'(cnt32), 64'h0);

    // streaming through the wrap point: enqueue and dequeue each cycle
    v32 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      src1 = 64'(32'h100 + i * 4);
      step();
      chk("wrap_addr", 64'(addr32), 64'(32'h100 + i * 4));
      chk("wrap_count", 64'(cnt32), 64'h1);
    end
    v32 = 1'b0;
    step();
    chk("wrap_empty", 64'(cnt32), 64'h0);

    // 32-bit store edge cases (rob_head already 7)
    load = 1'b0; store = 1'b1; rob = 5'd7; src2 = 64'h0;
    src1 = 64'h0; msg = 3'b011; src3 = 64'h12345678; v32 = 1'b1;
    step();
    v32 = 1'b0;
    chk("d32_mis", 64'(mis32), 64'h1);
    chk("d32_wmask", 64'(wm32), 64'hF);
    chk("d32_valid", 64'(ov32), 64'h1);
    chk("d32_wdata", 64'(wd32), 64'h12345678);
    step();
    src1 = 64'h3; msg = 3'b000; src3 = 64'h5A; v32 = 1'b1;
    step();
    v32 = 1'b0;
    chk("b32_wmask", 64'(wm32), 64'h8);
    chk("b32_wdata", 64'(wd32), 64'h5A5A5A5A);
    chk("b32_mis", 64'(mis32), 64'h0);
    step();
    src1 = 64'h2; msg = 3'b010; src3 = 64'hDEADBEEF; v32 = 1'b1;
    step();
    v32 = 1'b0;
    chk("w32_mis", 64'(mis32), 64'h1);
    chk("w32_wmask", 64'(wm32), 64'hF);
    step();
    load = 1'b1; store = 1'b0; src1 = 64'h10; msg = 3'b100; v32 = 1'b1;
    step();
    v32 = 1'b0;
    chk("ldu_unsigned", 64'(uns32), 64'h1);
    chk("ldu_wdata", 64'(wd32), 64'h0);
    step();

    // 64-bit datapath
    load = 1'b0; store = 1'b1; rob = 5'd7;
    src1 = 64'h1000; src2 = 64'h8; msg = 3'b011; src3 = 64'h1122334455667788; v64 = 1'b1;
    step();
    v64 = 1'b0;
    chk("d64_wmask", 64'(wm64), 64'hFF);
    chk("d64_mis", 64'(mis64), 64'h0);
    chk("d64_wdata", wd64, 64'h1122334455667788);
    chk("d64_addr", addr64, 64'h1008);
    step();
    src2 = 64'h4; v64 = 1'b1;
    step();
    v64 = 1'b0;
    chk("d64u_mis", 64'(mis64), 64'h1);
    step();
    msg = 3'b010; src3 = 64'hCAFEBABE; v64 = 1'b1;
    step();
    v64 = 1'b0;
    chk("w64_wmask", 64'(wm64), 64'hF0);
    chk("w64_wdata", wd64, 64'hCAFEBABECAFEBABE);
    chk("w64_mis", 64'(mis64), 64'h0);
    step();
    chk("d64_empty", 64'(cnt64), 64'h0);

    // flush with three entries queued and an op offered
    o_ready = 1'b0; load = 1'b1; store = 1'b0; msg = 3'b010; src2 = 64'h0; v32 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src1 = 64'(32'h200 + i * 4);
      step();
    end
    chk("fl_pre_count", 64'(cnt32), 64'h3);
    chk("fl_pre_valid", 64'(ov32), 64'h1);
    flush = 1'b1;
    #1;
    chk("fl_cycle_valid", 64'(ov32), 64'h0);
    step();
    flush = 1'b0;
    v32 = 1'b0;
    chk("fl_count", 64'(cnt32), 64'h0);
    chk("fl_valid", 64'(ov32), 64'h0);
    chk("fl_iready", 64'(irdy32), 64'h1);

    // reset mid-stream with two entries queued
    v32 = 1'b1;
    step();
    step();
    v32 = 1'b0;
    chk("rs_pre_count", 64'(cnt32), 64'h2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs_count", 64'(cnt32), 64'h0);
    chk("rs_iready", 64'(irdy32), 64'h1);
    chk("rs_valid", 64'(ov32), 64'h0);
    chk("rs_addr", 64'(addr32), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
